// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package uart_program_loader_pkg;

   typedef enum logic [2:0] {
      L_IDLE,
      L_COUNT,
      L_DATA,
      L_WRITE,
      L_DONE
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;

   // Word-count header length in bytes
   localparam int unsigned LOADER_HDR_BYTES = 4;

   // Little-endian byte insertion: idx 0 lands in bits [7:0]
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
      logic [31:0] res;
      res = word;
      res[{idx, 3'b000} +: 8] = b;
      return res;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Expects an already-synchronised line.
// Pulses byte_valid with data on a good stop bit, frame_err on a bad one.
module uart_rx
   import uart_program_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_sync,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

   uart_rx_state_t state;
   logic [CW-1:0]  clk_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift;
   logic           rx_prev;

   // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         rx_prev    <= 1'b1;
      end else begin
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_sync) begin
                  state <= RX_START;
               end
            end
            RX_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  // Line back high at mid start bit: treat as a glitch
                  state   <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= RX_STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  state   <= RX_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     data       <= shift;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a length-prefixed program over UART and writes it into instruction
// memory from word 0, holding the core in reset until the load completes.
module uart_program_loader
   import uart_program_loader_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned MAX_WORDS   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_serial,
   output logic        instr_wr_en,
   output logic [31:0] instr_wr_addr,
   output logic [31:0] instr_wr_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam logic [1:0]  HDR_LAST     = 2'(LOADER_HDR_BYTES - 1);

   logic          rx_meta;
   logic          rx_sync;
   logic [7:0]    rx_data;
   logic          byte_valid;
   logic          frame_err;

   loader_state_t state;
   logic [1:0]    byte_cnt;
   logic [31:0]   word_count;
   logic [31:0]   word_index;
   logic [31:0]   word_buf;
   logic [31:0]   count_next;
   logic [31:0]   word_next;
   logic [31:0]   index_next;

   // Two-flop synchroniser; idle-high reset avoids a false start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_sync <= rx_meta;
      end
   end

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx_sync    (rx_sync),
      .data       (rx_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // Header/word assembly with the incoming byte merged in
   always_comb begin
      count_next = insert_byte(word_count, byte_cnt, rx_data);
      word_next  = insert_byte(word_buf, byte_cnt, rx_data);
      index_next = word_index + 32'd1;
   end

   // Loader FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= L_IDLE;
         byte_cnt      <= '0;
         word_count    <= '0;
         word_index    <= '0;
         word_buf      <= '0;
         instr_wr_en   <= 1'b0;
         instr_wr_addr <= '0;
         instr_wr_data <= '0;
         cpu_hold      <= 1'b0;
         load_done     <= 1'b0;
         load_error    <= 1'b0;
      end else begin
         instr_wr_en <= 1'b0;
         load_done   <= 1'b0;
         if (frame_err && state != L_IDLE) begin
            // Abort keeps cpu_hold set so a partial program never runs
            load_error <= 1'b1;
            state      <= L_IDLE;
         end else begin
            case (state)
               L_IDLE: begin
                  if (frame_err) begin
                     load_error <= 1'b1;
                  end else if (byte_valid) begin
                     cpu_hold   <= 1'b1;
                     load_error <= 1'b0;
                     word_count <= {24'h0, rx_data};
                     byte_cnt   <= 2'd1;
                     state      <= L_COUNT;
                  end
               end
               L_COUNT: begin
                  if (byte_valid) begin
                     word_count <= count_next;
                     byte_cnt   <= byte_cnt + 2'd1;
                     if (byte_cnt == HDR_LAST) begin
                        word_index <= '0;
                        byte_cnt   <= '0;
                        if (count_next == 32'd0) begin
                           state <= L_DONE;
                        end else if (count_next > 32'(MAX_WORDS)) begin
                           load_error <= 1'b1;
                           state      <= L_IDLE;
                        end else begin
                           state <= L_DATA;
                        end
                     end
                  end
               end
               L_DATA: begin
                  if (byte_valid) begin
                     word_buf <= word_next;
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        state <= L_WRITE;
                     end
                  end
               end
               L_WRITE: begin
                  instr_wr_en   <= 1'b1;
                  instr_wr_addr <= {word_index[29:0], 2'b00};
                  instr_wr_data <= word_buf;
                  word_index    <= index_next;
                  byte_cnt      <= '0;
                  state         <= (index_next == word_count) ? L_DONE : L_DATA;
               end
               L_DONE: begin
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
                  state     <= L_IDLE;
               end
               default: state <= L_IDLE;
            endcase
         end
      end
   end

endmodule
